// File: rtl/ov7670_cfg_sequencer_if.sv
// SCCB transaction bus between the config sequencer and the I2C bit-level master.
// The master side issues one transaction per request; the slave side answers with done/nack/rdata.
interface ov7670_cfg_sequencer_if;
  logic       i2c_req;
  logic       i2c_rw;
  logic [7:0] i2c_dev;
  logic [7:0] i2c_reg;
  logic [7:0] i2c_wdata;
  logic       i2c_done;
  logic       i2c_nack;
  logic [7:0] i2c_rdata;

  modport master (
    output i2c_req, i2c_rw, i2c_dev, i2c_reg, i2c_wdata,
    input  i2c_done, i2c_nack, i2c_rdata
  );

  modport slave (
    input  i2c_req, i2c_rw, i2c_dev, i2c_reg, i2c_wdata,
    output i2c_done, i2c_nack, i2c_rdata
  );
endinterface

// File: rtl/ov7670_cfg_sequencer.sv
// OV7670 config sequencer: walks the config LUT, one SCCB transaction per entry,
// with ID-read compare, NACK retry, inter-transaction gap and restart on start.
module ov7670_cfg_sequencer #(
  parameter int          LUT_SIZE  = 167,
  parameter int          READ_NUM  = 2,
  parameter logic [7:0]  DEV_ADDR  = 8'h42,
  parameter logic [19:0] PWRUP_CYC = 20'd1000000,
  parameter logic [15:0] GAP_CYC   = 16'd1000,
  parameter int          MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  lut_index,
  input  logic [15:0] lut_data,
  ov7670_cfg_sequencer_if.master bus,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic        id_mismatch
);

  localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RMAX    = RW'(MAX_RETRY);
  localparam logic [7:0]    LAST    = 8'(LUT_SIZE - 1);
  localparam logic [8:0]    NRD     = 9'(READ_NUM);
  localparam logic [20:0]   PW_LIM  = {1'b0, PWRUP_CYC};
  localparam logic [20:0]   GAP_LIM = {5'd0, GAP_CYC};

  typedef enum logic [2:0] {
    S_PWRUP, S_LOAD, S_REQ, S_CHECK, S_GAP, S_DONE, S_ERR
  } state_t;

  state_t        state, state_nxt;
  logic          restart;
  logic [19:0]   cnt;
  logic [20:0]   cnt_inc;
  logic          pw_end, gap_end;
  logic [RW-1:0] retry;
  logic          start_pend;
  logic          nack_q;
  logic [7:0]    rdata_q;
  logic          rw_q;
  logic [7:0]    dev_q, reg_q, wdata_q;
  logic          rd_entry;

  assign cnt_inc  = {1'b0, cnt} + 21'd1;
  assign pw_end   = cnt_inc >= PW_LIM;
  assign gap_end  = cnt_inc >= GAP_LIM;
  assign rd_entry = {1'b0, lut_index} < NRD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_PWRUP;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    unique case (state)
      S_PWRUP: begin
        if (start)       restart   = 1'b1;
        else if (pw_end) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (start) restart   = 1'b1;
        else       state_nxt = S_REQ;
      end
      S_REQ: begin
        if (bus.i2c_done) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        // a start seen during REQ is only honoured once the bus is free
        if (start || start_pend)   restart   = 1'b1;
        else if (nack_q)           state_nxt = (retry < RMAX) ? S_GAP : S_ERR;
        else if (lut_index == LAST) state_nxt = S_DONE;
        else                       state_nxt = S_GAP;
      end
      S_GAP: begin
        if (start)        restart   = 1'b1;
        else if (gap_end) state_nxt = S_LOAD;
      end
      S_DONE, S_ERR: begin
        if (start) restart = 1'b1;
      end
      default: state_nxt = S_PWRUP;
    endcase
    if (restart) state_nxt = S_LOAD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      lut_index   <= '0;
      retry       <= '0;
      start_pend  <= 1'b0;
      id_mismatch <= 1'b0;
      nack_q      <= 1'b0;
      rdata_q     <= '0;
      rw_q        <= 1'b0;
      dev_q       <= '0;
      reg_q       <= '0;
      wdata_q     <= '0;
    end else begin
      if ((state_nxt == state) && (state == S_PWRUP || state == S_GAP))
        cnt <= cnt + 20'd1;
      else
        cnt <= '0;

      if (restart) begin
        lut_index   <= '0;
        retry       <= '0;
        start_pend  <= 1'b0;
        id_mismatch <= 1'b0;
      end else begin
        case (state)
          S_LOAD: begin
            reg_q   <= lut_data[15:8];
            wdata_q <= lut_data[7:0];
            rw_q    <= rd_entry;
            dev_q   <= DEV_ADDR | {7'd0, rd_entry};
          end
          S_REQ: begin
            if (start) start_pend <= 1'b1;
            if (bus.i2c_done) begin
              nack_q  <= bus.i2c_nack;
              rdata_q <= bus.i2c_rdata;
            end
          end
          S_CHECK: begin
            if (nack_q) begin
              if (retry < RMAX) retry <= retry + 1'b1;
            end else begin
              if (rw_q && (rdata_q != wdata_q)) id_mismatch <= 1'b1;
              retry <= '0;
              if (lut_index != LAST) lut_index <= lut_index + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.i2c_req   = (state == S_REQ);
  assign bus.i2c_rw    = rw_q;
  assign bus.i2c_dev   = dev_q;
  assign bus.i2c_reg   = reg_q;
  assign bus.i2c_wdata = wdata_q;

  assign cfg_busy  = !(state == S_DONE || state == S_ERR);
  assign cfg_done  = (state == S_DONE);
  assign cfg_error = (state == S_ERR);

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// Bench for ov7670_cfg_sequencer: behavioural SCCB slave plus a queue of
// expected transactions, covering nominal, ID mismatch, retry, abort, restart and reset.
module tb_ov7670_cfg_sequencer;
  localparam int N = 167;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  lut_index;
  logic [15:0] lut_data;
  logic        cfg_busy, cfg_done, cfg_error, id_mismatch;

  ov7670_cfg_sequencer_if bus();

  ov7670_cfg_sequencer #(
    .PWRUP_CYC(20'd100),
    .GAP_CYC  (16'd10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .lut_index  (lut_index),
    .lut_data   (lut_data),
    .bus        (bus.master),
    .cfg_busy   (cfg_busy),
    .cfg_done   (cfg_done),
    .cfg_error  (cfg_error),
    .id_mismatch(id_mismatch)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [32:0] sb[$];
  int nack_idx = 255;
  int nack_left = 0;
  bit bad_id = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lut_f(input logic [7:0] i);
    case (i)
      8'd0:    return 16'h0A76;
      8'd1:    return 16'h0B73;
      8'd4:    return 16'h1204;
      8'd10:   return 16'h0C3C;
      default: return {i + 8'h20, i ^ 8'h5A};
    endcase
  endfunction

  assign lut_data = lut_f(lut_index);

  function automatic logic [32:0] exp_txn(input int i);
    logic [7:0] ix;
    logic       rw;
    ix = 8'(i);
    rw = (i < 2);
    return {ix, rw, 8'h42 | {7'd0, rw}, lut_f(ix)};
  endfunction

  task automatic push_run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) sb.push_back(exp_txn(i));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(cfg_done || cfg_error) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("run_end", cfg_done || cfg_error, 1);
  endtask

  task automatic wait_idx(input string tag, input logic [7:0] ix);
    int n;
    n = 0;
    while (!(bus.i2c_req && lut_index == ix) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, bus.i2c_req && lut_index == ix, 1);
  endtask

  task automatic pwrup_lat(input string tag);
    int n;
    n = 0;
    while (!bus.i2c_req && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n, 101);
  endtask

  // behavioural slave: done 50 cycles after the request rises
  initial begin
    logic [32:0] cur;
    logic [7:0]  ix;
    int  wcnt;
    bit  active;
    bit  was_done;
    cur = '0;
    wcnt = 0;
    active = 1'b0;
    was_done = 1'b0;
    bus.i2c_done  = 1'b0;
    bus.i2c_nack  = 1'b0;
    bus.i2c_rdata = 8'h00;
    forever begin
      @(negedge clk);
      bus.i2c_done = 1'b0;
      bus.i2c_nack = 1'b0;
      if (was_done) chk("req_drop", bus.i2c_req, 0);
      was_done = 1'b0;
      if (rst) begin
        active = 1'b0;
      end else if (!active && bus.i2c_req) begin
        active = 1'b1;
        wcnt = 0;
        chk("sb_nonempty", sb.size() != 0, 1);
        cur = (sb.size() != 0) ? sb.pop_front() : '0;
        chk("txn", {lut_index, bus.i2c_rw, bus.i2c_dev,
                    bus.i2c_reg, bus.i2c_wdata}, cur);
      end else if (active) begin
        wcnt++;
        if (wcnt == 49) begin
          chk("stable", {lut_index, bus.i2c_req, bus.i2c_rw, bus.i2c_dev,
                         bus.i2c_reg, bus.i2c_wdata}, {cur[32:25], 1'b1, cur[24:0]});
          ix = cur[32:25];
          bus.i2c_done = 1'b1;
          if (int'(ix) == nack_idx && nack_left > 0) begin
            bus.i2c_nack = 1'b1;
            nack_left--;
          end
          if (ix == 8'd0 && bad_id) begin
            bus.i2c_rdata = 8'h00;
            bad_id = 1'b0;
          end else if (ix < 8'd2) begin
            bus.i2c_rdata = cur[7:0];
          end else begin
            bus.i2c_rdata = 8'($urandom);
          end
          active = 1'b0;
          was_done = 1'b1;
        end
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", cfg_busy, 1);
    chk("rst_flags", {cfg_done, cfg_error, id_mismatch}, 0);
    chk("rst_idx", lut_index, 0);
    chk("rst_bus", {bus.i2c_req, bus.i2c_rw, bus.i2c_dev,
                    bus.i2c_reg, bus.i2c_wdata}, 0);

    // T1 nominal
    push_run(0, N - 1);
    rst = 1'b0;
    pwrup_lat("t1_pwrup");
    wait_end();
    chk("t1_flags", {cfg_done, cfg_error, id_mismatch, cfg_busy}, 4'b1000);
    chk("t1_idx", lut_index, N - 1);
    chk("t1_sb_left", sb.size(), 0);

    // T2 ID mismatch at index 0
    bad_id = 1'b1;
    push_run(0, N - 1);
    pulse_start();
    wait_end();
    chk("t2_flags", {cfg_done, cfg_error, id_mismatch}, 3'b101);
    chk("t2_sb_left", sb.size(), 0);

    // T3 two NACKs at index 10
    nack_idx = 10;
    nack_left = 2;
    push_run(0, 10);
    push_run(10, 10);
    push_run(10, N - 1);
    pulse_start();
    wait_end();
    chk("t3_flags", {cfg_done, cfg_error, id_mismatch}, 3'b100);
    chk("t3_sb_left", sb.size(), 0);

    // T4 persistent NACK at index 5
    nack_idx = 5;
    nack_left = 1000;
    push_run(0, 5);
    for (int k = 0; k < 3; k++) push_run(5, 5);
    pulse_start();
    wait_end();
    repeat (30) @(negedge clk);
    chk("t4_flags", {cfg_done, cfg_error, cfg_busy, bus.i2c_req}, 4'b0100);
    chk("t4_idx", lut_index, 5);
    chk("t4_sb_left", sb.size(), 0);
    nack_idx = 255;
    nack_left = 0;

    // T5 start during REQ at index 30
    bad_id = 1'b1;
    push_run(0, 30);
    push_run(0, N - 1);
    pulse_start();
    wait_idx("t5_reach", 8'd30);
    chk("t5_mm_pre", id_mismatch, 1);
    repeat (3) @(negedge clk);
    pulse_start();
    n = 0;
    while (bus.i2c_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!bus.i2c_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t5_restart_gap", n, 2);
    chk("t5_idx0", lut_index, 0);
    chk("t5_mm_clr", id_mismatch, 0);
    wait_end();
    chk("t5_flags", {cfg_done, cfg_error, id_mismatch}, 3'b100);
    chk("t5_sb_left", sb.size(), 0);

    // T6 reset mid-transaction at index 80
    push_run(0, 80);
    pulse_start();
    wait_idx("t6_reach", 8'd80);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_async", {bus.i2c_req, lut_index, cfg_busy}, {1'b0, 8'd0, 1'b1});
    repeat (3) @(negedge clk);
    chk("t6_sb_left_a", sb.size(), 0);
    push_run(0, N - 1);
    rst = 1'b0;
    pwrup_lat("t6_pwrup");
    wait_end();
    chk("t6_flags", {cfg_done, cfg_error, id_mismatch}, 3'b100);
    chk("t6_sb_left", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
